// File: rtl/prio_scan_decoder_if.sv
// rtl/prio_scan_decoder_if.sv - request/index handshake bundle for prio_scan_decoder
interface prio_scan_decoder_if #(
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    // Producer of request vectors and consumer of indices.
    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_idx,
        input  out_last
    );

    // The decoder itself.
    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_idx,
        output out_last
    );
endinterface

// File: rtl/prio_scan_decoder.sv
// rtl/prio_scan_decoder.sv - sequential highest-first set-bit index emitter (optional PRIO_SCAN_COUNT_EN adds rem_cnt)
module prio_scan_decoder #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    prio_scan_decoder_if.slave           bus,
    output logic                         zero_vec,
    output logic                         busy
`ifdef PRIO_SCAN_COUNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0]   rem_cnt
`endif
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pending;
    logic [IDX_W-1:0] hi_idx;
    logic             one_left;
    logic [WIDTH-1:0] clr_mask;
    logic             accept;
    logic             serve;

    // Handshake qualifiers: vectors only enter in IDLE, indices only leave in SCAN.
    assign accept = (state == IDLE) && bus.in_valid;
    assign serve  = (state == SCAN) && bus.out_ready;

    // Highest set bit of pending; later (higher) hits overwrite lower ones.
    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pending[i]) begin
                hi_idx = IDX_W'(i);
            end
        end
    end

    // Exactly one bit left means the index now on offer is the last of the vector.
    always_comb begin
        one_left = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);
        clr_mask = {{(WIDTH-1){1'b0}}, 1'b1} << hi_idx;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: enter SCAN on a non-zero vector, leave after the last index is taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && (bus.in_vec != '0)) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (serve && one_left) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pending bits load on accept and lose the served bit on every output handshake;
    // zero_vec flags an accepted empty vector for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            zero_vec <= 1'b0;
        end else begin
            zero_vec <= accept && (bus.in_vec == '0);
            if (accept) begin
                pending <= bus.in_vec;
            end else if (serve) begin
                pending <= pending & ~clr_mask;
            end
        end
    end

    // Outputs are pure functions of state and pending, so they hold through stalls.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        busy          = (state == SCAN);
        bus.out_valid = (state == SCAN);
        bus.out_idx   = hi_idx;
        bus.out_last  = one_left;
    end

`ifdef PRIO_SCAN_COUNT_EN
    localparam int CNT_W = $clog2(WIDTH+1);

    // Remaining count is the population count of pending, zero whenever idle.
    always_comb begin
        rem_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rem_cnt = rem_cnt + CNT_W'(pending[i]);
        end
    end
`endif

endmodule

// File: tb/tb_prio_scan_decoder.sv
// tb/tb_prio_scan_decoder.sv - randomized self-checking bench for prio_scan_decoder
module tb_prio_scan_decoder;
    logic        clk;
    logic        rst;
    logic        sel;
    logic        in_valid;
    logic [31:0] in_vec;
    logic        out_ready;
    int          checks;
    int          failures;

    prio_scan_decoder_if #(.WIDTH(8))  bus8 ();
    prio_scan_decoder_if #(.WIDTH(32)) bus32 ();

    logic       zero8, busy8, zero32, busy32;
    logic [3:0] rem8;
    logic [5:0] rem32;

    assign bus8.in_valid   = in_valid & ~sel;
    assign bus8.in_vec     = in_vec[7:0];
    assign bus8.out_ready  = out_ready;
    assign bus32.in_valid  = in_valid & sel;
    assign bus32.in_vec    = in_vec;
    assign bus32.out_ready = out_ready;

    prio_scan_decoder #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus8.slave),
        .zero_vec (zero8),
        .busy     (busy8)
`ifdef PRIO_SCAN_COUNT_EN
        ,
        .rem_cnt  (rem8)
`endif
    );

    prio_scan_decoder #(.WIDTH(32)) dut32 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus32.slave),
        .zero_vec (zero32),
        .busy     (busy32)
`ifdef PRIO_SCAN_COUNT_EN
        ,
        .rem_cnt  (rem32)
`endif
    );

`ifndef PRIO_SCAN_COUNT_EN
    assign rem8  = '0;
    assign rem32 = '0;
`endif

    logic       o_in_ready, o_valid, o_last, o_zero, o_busy;
    logic [4:0] o_idx;
    logic [5:0] o_rem;
    assign o_in_ready = sel ? bus32.in_ready  : bus8.in_ready;
    assign o_valid    = sel ? bus32.out_valid : bus8.out_valid;
    assign o_last     = sel ? bus32.out_last  : bus8.out_last;
    assign o_idx      = sel ? bus32.out_idx   : {2'b00, bus8.out_idx};
    assign o_zero     = sel ? zero32 : zero8;
    assign o_busy     = sel ? busy32 : busy8;
    assign o_rem      = sel ? rem32  : {2'b00, rem8};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_idle(input string tag);
        checks++;
        if (o_valid !== 1'b0 || o_in_ready !== 1'b1 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle: valid=%b in_ready=%b busy=%b required 0/1/0", tag, o_valid, o_in_ready, o_busy);
        end
`ifdef PRIO_SCAN_COUNT_EN
        checks++;
        if (o_rem !== 6'd0) begin
            failures++;
            $display("FAIL %s_rem_idle: rem_cnt=%0d required 0", tag, o_rem);
        end
`endif
    endtask

    // Expected beats: set bits listed from the top down, last flag on the final one.
    task automatic run_vec(input logic [31:0] v, input int w, input int mode, input string tag);
        int          exp_q[$];
        int          cyc;
        int          wait_cnt;
        logic        rdy;
        logic [31:0] vv;
        vv = (w == 32) ? v : (v & 32'h0000_00FF);
        for (int i = w - 1; i >= 0; i--) begin
            if (vv[i]) exp_q.push_back(i);
        end
        @(negedge clk);
        wait_cnt = 0;
        while (o_in_ready !== 1'b1 && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        if (o_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_accept_ready: in_ready=%b required 1", tag, o_in_ready);
        end
        in_valid  = 1'b1;
        in_vec    = vv;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (exp_q.size() == 0) begin
            checks++;
            if (o_zero !== 1'b1 || o_valid !== 1'b0 || o_in_ready !== 1'b1) begin
                failures++;
                $display("FAIL %s_zero_pulse: zero_vec=%b valid=%b in_ready=%b required 1/0/1", tag, o_zero, o_valid, o_in_ready);
            end
            @(negedge clk);
            checks++;
            if (o_zero !== 1'b0 || o_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s_zero_end: zero_vec=%b valid=%b required 0/0", tag, o_zero, o_valid);
            end
            return;
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 400) begin
            checks++;
            if (o_valid !== 1'b1 || o_busy !== 1'b1 || o_in_ready !== 1'b0 || o_zero !== 1'b0) begin
                failures++;
                $display("FAIL %s_scan_flags: valid=%b busy=%b in_ready=%b zero=%b required 1/1/0/0", tag, o_valid, o_busy, o_in_ready, o_zero);
            end
            checks++;
            if ({27'd0, o_idx} !== exp_q[0]) begin
                failures++;
                $display("FAIL %s_idx: out_idx=%0d required %0d", tag, o_idx, exp_q[0]);
            end
            checks++;
            if (o_last !== (exp_q.size() == 1)) begin
                failures++;
                $display("FAIL %s_last: out_last=%b required %b", tag, o_last, exp_q.size() == 1);
            end
`ifdef PRIO_SCAN_COUNT_EN
            checks++;
            if ({26'd0, o_rem} !== exp_q.size()) begin
                failures++;
                $display("FAIL %s_rem: rem_cnt=%0d required %0d", tag, o_rem, exp_q.size());
            end
`endif
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = ((cyc % 3) == 0);
            endcase
            out_ready = rdy;
            in_valid  = 1'($urandom_range(0, 1));
            in_vec    = $urandom;
            @(posedge clk);
            if (rdy) void'(exp_q.pop_front());
            cyc++;
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b0;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: %0d beats outstanding required 0", tag, exp_q.size());
        end
        check_idle(tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || o_idx !== 5'd0 || o_last !== 1'b0 || o_zero !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b idx=%0d last=%b zero=%b busy=%b required all 0", o_valid, o_idx, o_last, o_zero, o_busy);
        end
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
    endtask

    task automatic test_directed();
        sel = 1'b0;
        run_vec(32'hA6, 8, 0, "a6");
        run_vec(32'h00, 8, 0, "zero8");
        run_vec(32'h01, 8, 0, "bit0");
        run_vec(32'hFF, 8, 2, "ff_stall");
        run_vec(32'h80, 8, 1, "bit7");
    endtask

    task automatic test_rst_mid_scan();
        sel = 1'b0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_vec    = 32'hF0;
        out_ready = 1'b1;
        @(posedge clk);
        for (int b = 7; b >= 6; b--) begin
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (o_valid !== 1'b1 || {27'd0, o_idx} !== b) begin
                failures++;
                $display("FAIL rst_scan_beat: valid=%b idx=%0d required 1/%0d", o_valid, o_idx, b);
            end
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (o_idx !== 5'd0 || o_last !== 1'b0) begin
            failures++;
            $display("FAIL rst_scan_outputs: idx=%0d last=%b required 0/0", o_idx, o_last);
        end
        check_idle("rst_scan");
        run_vec(32'h02, 8, 0, "after_rst");
    endtask

    task automatic test_random();
        sel = 1'b0;
        for (int n = 0; n < 30; n++) begin
            run_vec($urandom, 8, n % 3, "rand8");
        end
    endtask

    task automatic test_wide();
        sel = 1'b1;
        run_vec(32'h8000_0001, 32, 0, "wide_ends");
        run_vec(32'h0000_0000, 32, 0, "zero32");
        run_vec(32'hFFFF_FFFF, 32, 1, "ones32");
        for (int n = 0; n < 8; n++) begin
            run_vec($urandom, 32, n % 3, "rand32");
        end
        sel = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        sel       = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_rst_mid_scan();
        test_random();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
